aes_stream_controller: RTL

//  Multi-block successor to the single-shot AES controller. Buffers DEPTH

---
 rtl/aes_stream_controller.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/aes_stream_controller.sv
// -----------------------------------------------------------------------------
// aes_stream_controller
// Buffers up to DEPTH ciphertext blocks and feeds them one at a time to an
// external inverse-AES core over a level Run / Ready handshake. Each result is
// held on a valid/ready output until taken. Adds a per-block RUN timeout
// (sticky error) and a key-load port that is only honoured while idle.
//
// Ports
//   clk, reset_n            clock (posedge), async active-low reset
//   in_valid/in_ready/in_data    block input; in_ready = FIFO not full
//   key_load/key_in/key_ack      key load request, 1-cycle acknowledge
//   out_valid/out_ready/out_data result output, valid only in HOLD
//   core_run/core_key/core_text  registered drive to the AES core
//   core_result/core_done        core response (sampled only in RUN)
//   busy                         controller active or FIFO non-empty
//   timeout_err                  sticky abort flag, cleared by reset only
//   blocks_done                  wrapping count of delivered results
// -----------------------------------------------------------------------------
module aes_stream_controller #(
  parameter int DATA_W  = 128,
  parameter int KEY_W   = 128,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              key_load,
  input  logic [KEY_W-1:0]  key_in,
  output logic              key_ack,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              core_run,
  output logic [KEY_W-1:0]  core_key,
  output logic [DATA_W-1:0] core_text,
  input  logic [DATA_W-1:0] core_result,
  input  logic              core_done,
  output logic              busy,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  blocks_done
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TMR_W = $clog2(TIMEOUT) + 1;

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   ZERO_CNT = {(PTR_W + 1){1'b0}};
  localparam logic [PTR_W:0]   ONE_CNT  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);
  localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DONE_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [DATA_W-1:0] fifo_mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [PTR_W:0]    count_r;
  logic [TMR_W-1:0]  timer_r;

  logic push_s, pop_s, key_take_s, run_done_s, abort_s, deliver_s;

  assign in_ready = (count_r != FULL_CNT);
  assign busy     = (state_r != ST_IDLE) || (count_r != ZERO_CNT);
  assign push_s   = in_valid && in_ready;

  // Next-state decode and per-cycle action strobes.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    key_take_s  = 1'b0;
    run_done_s  = 1'b0;
    abort_s     = 1'b0;
    deliver_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // A key load blocks a block start in the same cycle so the new key
        // is in place before the next RUN begins.
        if (key_load) begin
          key_take_s = 1'b1;
        end else if (count_r != ZERO_CNT) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // core_done takes precedence over an expiring timer.
        if (core_done) begin
          run_done_s  = 1'b1;
          state_nxt_s = ST_HOLD;
        end else if (timer_r == TMR_LAST) begin
          abort_s     = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          deliver_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_nxt_s;
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) fifo_mem_r[wr_ptr_r] <= in_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= ZERO_CNT;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + ONE_PTR;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + ONE_PTR;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + ONE_CNT;
        2'b01:   count_r <= count_r - ONE_CNT;
        default: count_r <= count_r;
      endcase
    end
  end

  // RUN timer: restarts when a block is launched, counts RUN cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               timer_r <= TMR_ZERO;
    else if (pop_s)             timer_r <= TMR_ZERO;
    else if (state_r == ST_RUN) timer_r <= timer_r + TMR_ONE;
  end

  // Registered outputs towards the core and the consumer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_run    <= 1'b0;
      core_key    <= {KEY_W{1'b0}};
      core_text   <= {DATA_W{1'b0}};
      key_ack     <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= {DATA_W{1'b0}};
      timeout_err <= 1'b0;
      blocks_done <= {CNT_W{1'b0}};
    end else begin
      core_run  <= (state_nxt_s == ST_RUN);
      out_valid <= (state_nxt_s == ST_HOLD);
      key_ack   <= key_take_s;
      if (key_take_s) core_key    <= key_in;
      if (pop_s)      core_text   <= fifo_mem_r[rd_ptr_r];
      if (run_done_s) out_data    <= core_result;
      if (abort_s)    timeout_err <= 1'b1;
      if (deliver_s)  blocks_done <= blocks_done + DONE_ONE;
    end
  end

endmodule
